// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: gray/binary read pointer, empty
// detection, fill level, and a one-entry prefetch register with valid/ready output.
module async_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rreset,
  input  logic [ADDR_WIDTH:0]   r_wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  rerr
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] rbin_r;
  logic [PW-1:0] rbin_next_s;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] rlevel_s;
  logic          rempty_s;
  logic          fetch_s;

  // Empty/level decode and the fetch decision for this cycle
  always_comb begin
    rbin_next_s = rbin_r + ONE_C;
    wbin_s      = gray2bin(r_wptr);
    rlevel_s    = wbin_s - rbin_r;
    rempty_s    = (rptr == r_wptr);
    fetch_s     = !rempty_s && (!m_valid || m_ready);
  end

  assign raddr  = rbin_r[ADDR_WIDTH-1:0];
  assign rempty = rempty_s;
  assign rlevel = rlevel_s;

  // Pointer, prefetch register and sticky error state
  always_ff @(posedge rclk) begin
    if (rreset) begin
      rbin_r  <= {PW{1'b0}};
      rptr    <= {PW{1'b0}};
      m_valid <= 1'b0;
      m_data  <= {DATA_WIDTH{1'b0}};
      rerr    <= 1'b0;
    end else begin
      if (fetch_s) begin
        m_data  <= mem_rdata;
        m_valid <= 1'b1;
        rbin_r  <= rbin_next_s;
        rptr    <= bin2gray(rbin_next_s);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end else begin
        m_valid <= m_valid;
      end
      // A level above depth can only come from a corrupted pointer
      if (rlevel_s > DEPTH_C) begin
        rerr <= 1'b1;
      end else begin
        rerr <= rerr;
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed self-checking bench for async_fifo_rd_ctrl; the bench plays both the
// write side (memory + gray write pointer) and the consumer.
module tb_async_fifo_rd_ctrl;

  logic       rclk;
  logic       rreset;
  logic [3:0] r_wptr;
  logic [3:0] rptr;
  logic [2:0] raddr;
  logic [7:0] mem_rdata;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       rempty;
  logic [3:0] rlevel;
  logic       rerr;

  logic [7:0] mem [8];
  int n_assert = 0;
  int n_fail   = 0;

  assign mem_rdata = mem[raddr];

  async_fifo_rd_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .rclk(rclk), .rreset(rreset), .r_wptr(r_wptr), .rptr(rptr), .raddr(raddr),
    .mem_rdata(mem_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .rempty(rempty), .rlevel(rlevel), .rerr(rerr)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic int gray_to_int(input logic [3:0] g);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      v = (v << 1) | (((v & 1) ^ int'(g[i])) & 1);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rreset = 1'b1;
    r_wptr = 4'b0000;
    tick();
    rreset = 1'b0;
  endtask

  initial begin
    int tx;
    int rx;
    int cyc;
    int wb;
    logic [3:0] prev_rptr;

    rreset  = 1'b0;
    m_ready = 1'b0;
    r_wptr  = 4'b0000;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    #2;

    // Reset state
    do_reset();
    chk("rst_rempty", rempty, 1);
    chk("rst_valid", m_valid, 0);
    chk("rst_rptr", rptr, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_rlevel", rlevel, 0);
    chk("rst_rerr", rerr, 0);

    // Single word, then backpressure, then drain
    mem[0] = 8'hA5;
    r_wptr = gray(1);
    #1;
    chk("one_rempty_fall", rempty, 0);
    chk("one_rlevel", rlevel, 1);
    tick();
    chk("one_valid", m_valid, 1);
    chk("one_data", m_data, 8'hA5);
    chk("one_rptr", rptr, 4'b0001);
    chk("one_raddr", raddr, 1);
    chk("one_rempty", rempty, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", m_data, 8'hA5);
      chk("stall_valid", m_valid, 1);
    end
    m_ready = 1'b1;
    tick();
    chk("drain_valid", m_valid, 0);
    chk("drain_rempty", rempty, 1);
    chk("drain_data_hold", m_data, 8'hA5);

    // Full memory streamed back-to-back
    m_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
    r_wptr  = gray(8);
    m_ready = 1'b1;
    #1;
    chk("full_rlevel", rlevel, 8);
    chk("full_rempty", rempty, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("burst_valid", m_valid, 1);
      chk("burst_data", m_data, 32'(8'h10 + k));
    end
    chk("burst_rptr", rptr, 4'b1100);
    chk("burst_rempty", rempty, 1);
    chk("burst_rerr", rerr, 0);
    tick();
    chk("burst_end_valid", m_valid, 0);

    // 20 words with alternating ready, pointer wraps through 15 -> 0
    tx = 0; rx = 0; cyc = 0; wb = 8;
    prev_rptr = rptr;
    while (rx < 20 && cyc < 200) begin
      if (rptr !== prev_rptr) chk("rptr_one_bit", $countones(rptr ^ prev_rptr), 1);
      prev_rptr = rptr;
      m_ready = (cyc % 2 == 0);
      if (tx < 20 && ((wb - gray_to_int(rptr)) & 15) < 8) begin
        mem[3'(wb)] = 8'(8'h40 + tx);
        wb = (wb + 1) % 16;
        tx++;
        r_wptr = gray(wb);
      end
      #1;
      if (m_valid && m_ready) begin
        chk("stream_data", m_data, 32'(8'h40 + rx));
        rx++;
      end
      tick();
      cyc++;
    end
    chk("stream_count", rx, 20);
    chk("stream_rptr", rptr, 4'b1010);
    chk("stream_raddr", raddr, 3'd4);
    chk("stream_rempty", rempty, 1);
    chk("stream_valid", m_valid, 0);

    // Reset mid-transfer with a word held in the output register
    m_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h20 + i);
    r_wptr = gray(6);
    tick();
    m_ready = 1'b1;
    repeat (4) tick();
    chk("pre_rst_rptr", rptr, 4'b0111);
    chk("pre_rst_data", m_data, 8'h24);
    chk("pre_rst_valid", m_valid, 1);
    rreset = 1'b1;
    tick();
    rreset = 1'b0;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_rptr", rptr, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_rerr", rerr, 0);
    chk("mid_rst_rlevel", rlevel, 6);

    // Corrupt write pointer -> sticky error until reset
    m_ready = 1'b0;
    r_wptr  = 4'b1010;
    #1;
    chk("err_rlevel", rlevel, 12);
    chk("err_before", rerr, 0);
    tick();
    chk("err_set", rerr, 1);
    r_wptr = gray(1);
    #1;
    chk("err_restored_level", rlevel, 0);
    repeat (3) tick();
    chk("err_sticky", rerr, 1);
    rreset = 1'b1;
    tick();
    rreset = 1'b0;
    chk("err_cleared", rerr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
